// File: rtl/ram8_arbiter.sv
// Two-port arbiter/sequencer sharing one RAM8 macro (8x32, byte enables,
// registered read). One access per three cycles: IDLE -> ACCESS -> RESP.
module ram8_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [3:0]  we0,
    input  logic [2:0]  a0,
    input  logic [31:0] di0,
    output logic        ack0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic [3:0]  we1,
    input  logic [2:0]  a1,
    input  logic [31:0] di1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [2:0]  ram_a,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          state_q;
    logic            owner_q;
    logic            rr_ptr_q;
    logic            ram_en_q;
    logic [BW-1:0]   ram_we_q;
    logic [AW-1:0]   ram_a_q;
    logic [DW-1:0]   ram_di_q;

    logic            win1_c;
    logic            resp_c;

    // Port 1 wins when alone, or when both request and it holds RR priority.
    assign win1_c = req1 & (~req0 | (RR_EN & rr_ptr_q));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= '0;
            ram_a_q  <= '0;
            ram_di_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        owner_q  <= win1_c;
                        ram_en_q <= 1'b1;
                        ram_we_q <= win1_c ? we1 : we0;
                        ram_a_q  <= win1_c ? a1  : a0;
                        ram_di_q <= win1_c ? di1 : di0;
                        state_q  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ram_en_q <= 1'b0;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (RR_EN) begin
                        rr_ptr_q <= ~owner_q;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    ram_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_en = ram_en_q;
    assign ram_we = ram_we_q;
    assign ram_a  = ram_a_q;
    assign ram_di = ram_di_q;

    // Response is combinational: RAM read data is only valid during RESP.
    assign resp_c = (state_q == ST_RESP);
    assign ack0   = resp_c & ~owner_q;
    assign ack1   = resp_c &  owner_q;
    assign rdata0 = ack0 ? ram_do : '0;
    assign rdata1 = ack1 ? ram_do : '0;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: round-robin instance (a) and fixed-priority
// instance (b), each with its own behavioural RAM8 and scoreboard.
module tb_ram8_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ram_init = 1'b1;

    logic [1:0]  req_a = '0;
    logic [3:0]  we_a [2];
    logic [2:0]  adr_a [2];
    logic [31:0] di_a [2];
    logic        ack0_a, ack1_a;
    logic [31:0] rdata0_a, rdata1_a;
    logic        ram_en_a;
    logic [3:0]  ram_we_a;
    logic [2:0]  ram_a_a;
    logic [31:0] ram_di_a, ram_do_a;
    logic [31:0] mem_a [8];

    logic [1:0]  req_b = '0;
    logic [2:0]  adr_b [2];
    logic        ack0_b, ack1_b;
    logic [31:0] rdata0_b, rdata1_b;
    logic        ram_en_b;
    logic [3:0]  ram_we_b;
    logic [2:0]  ram_a_b;
    logic [31:0] ram_di_b, ram_do_b;
    logic [31:0] mem_b [8];

    logic [31:0] ref_a [8];
    logic [31:0] ref_b [8];
    exp_t        sb_a [$];
    exp_t        sb_b [$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    ram8_arbiter #(.RR_EN(1'b1)) u_dut_a (
        .CLK(CLK), .RST(RST),
        .req0(req_a[0]), .we0(we_a[0]), .a0(adr_a[0]), .di0(di_a[0]),
        .ack0(ack0_a), .rdata0(rdata0_a),
        .req1(req_a[1]), .we1(we_a[1]), .a1(adr_a[1]), .di1(di_a[1]),
        .ack1(ack1_a), .rdata1(rdata1_a),
        .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_a(ram_a_a),
        .ram_di(ram_di_a), .ram_do(ram_do_a)
    );

    ram8_arbiter #(.RR_EN(1'b0)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .req0(req_b[0]), .we0(4'h0), .a0(adr_b[0]), .di0(32'h0),
        .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req_b[1]), .we1(4'h0), .a1(adr_b[1]), .di1(32'h0),
        .ack1(ack1_b), .rdata1(rdata1_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_a(ram_a_b),
        .ram_di(ram_di_b), .ram_do(ram_do_b)
    );

    // RAM8 models: registered read-before-write, output zeroed when disabled.
    always @(posedge CLK) begin
        if (ram_init) begin
            for (int k = 0; k < 8; k++) begin
                mem_a[k] <= 32'hA000_0000 + 32'(k);
                mem_b[k] <= 32'hB000_0000 + 32'(k);
            end
            ram_do_a <= '0;
            ram_do_b <= '0;
        end else begin
            if (ram_en_a) begin
                ram_do_a <= mem_a[ram_a_a];
                for (int b = 0; b < 4; b++)
                    if (ram_we_a[b]) mem_a[ram_a_a][8*b +: 8] <= ram_di_a[8*b +: 8];
            end else begin
                ram_do_a <= '0;
            end
            if (ram_en_b) begin
                ram_do_b <= mem_b[ram_a_b];
                for (int b = 0; b < 4; b++)
                    if (ram_we_b[b]) mem_b[ram_a_b][8*b +: 8] <= ram_di_b[8*b +: 8];
            end else begin
                ram_do_b <= '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic pop_a();
        exp_t e;
        if (sb_a.size() == 0) begin
            check("a_sb_underflow", 32'(sb_a.size()), 32'd1);
            return;
        end
        e = sb_a.pop_front();
        check("a_ack_port", 32'(ack1_a), 32'(e.port));
        check("a_rdata", e.port ? rdata1_a : rdata0_a, e.data);
        check("a_other_rdata", e.port ? rdata0_a : rdata1_a, 32'h0);
    endtask

    task automatic pop_b();
        exp_t e;
        if (sb_b.size() == 0) begin
            check("b_sb_underflow", 32'(sb_b.size()), 32'd1);
            return;
        end
        e = sb_b.pop_front();
        check("b_ack_port", 32'(ack1_b), 32'(e.port));
        check("b_rdata", e.port ? rdata1_b : rdata0_b, e.data);
    endtask

    // Single access on instance a, checking latency and scoreboarded rdata.
    task automatic do_op(input int p, input logic [3:0] we, input logic [2:0] a,
                         input logic [31:0] di);
        int n;
        exp_t e;
        @(negedge CLK);
        we_a[p] = we; adr_a[p] = a; di_a[p] = di; req_a[p] = 1'b1;
        e.port = p[0];
        e.data = ref_a[a];
        sb_a.push_back(e);
        for (int b = 0; b < 4; b++)
            if (we[b]) ref_a[a][8*b +: 8] = di[8*b +: 8];
        @(negedge CLK);
        check("op_en_e1", 32'(ram_en_a), 32'd1);
        check("op_ack_e1", 32'(ack0_a | ack1_a), 32'd0);
        n = 1;
        while (!(ack0_a | ack1_a) && n < 6) begin
            @(negedge CLK);
            n++;
        end
        check("op_ack_latency", 32'(n), 32'd2);
        check("op_en_at_ack", 32'(ram_en_a), 32'd0);
        if (ack0_a | ack1_a) pop_a();
        else void'(sb_a.pop_front());
        req_a[p] = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   last_a, n_ack_a, n_ack0_b, n_ack1_b, got;
        for (int k = 0; k < 2; k++) begin
            we_a[k] = '0; adr_a[k] = '0; di_a[k] = '0; adr_b[k] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            ref_a[k] = 32'hA000_0000 + 32'(k);
            ref_b[k] = 32'hB000_0000 + 32'(k);
        end

        // T1: reset held with both requests high.
        req_a = 2'b11;
        req_b = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rst_en_a", 32'(ram_en_a), 32'd0);
            check("rst_ack_a", 32'({ack1_a, ack0_a}), 32'd0);
            check("rst_rdata_a", rdata0_a | rdata1_a, 32'h0);
            check("rst_en_b", 32'(ram_en_b), 32'd0);
            check("rst_ack_b", 32'({ack1_b, ack0_b}), 32'd0);
            check("rst_rdata_b", rdata0_b | rdata1_b, 32'h0);
        end
        check("rst_ram_bus_a", 32'(ram_we_a) | 32'(ram_a_a) | ram_di_a, 32'h0);
        req_a = 2'b00;
        req_b = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
        ram_init = 1'b0;

        // T2 / T3: full write, read back, partial write returning old data.
        do_op(0, 4'hF, 3'd3, 32'hDEAD_BEEF);
        do_op(0, 4'h0, 3'd3, 32'h0);
        do_op(1, 4'b0010, 3'd3, 32'h0000_AA00);
        do_op(1, 4'h0, 3'd3, 32'h0);
        check("t3_partial_ref", ref_a[3], 32'hDEAD_AAEF);

        // T6: write aborted by reset during ACCESS leaves RAM untouched.
        do_op(0, 4'hF, 3'd5, 32'h1234_5678);
        @(negedge CLK);
        we_a[0] = 4'hF; adr_a[0] = 3'd5; di_a[0] = 32'hFFFF_FFFF; req_a[0] = 1'b1;
        @(negedge CLK);
        check("t6_en_access", 32'(ram_en_a), 32'd1);
        RST = 1'b1;
        #1;
        check("t6_en_drop", 32'(ram_en_a), 32'd0);
        @(negedge CLK);
        check("t6_no_ack", 32'({ack1_a, ack0_a}), 32'd0);
        req_a[0] = 1'b0;
        RST = 1'b0;
        do_op(0, 4'h0, 3'd5, 32'h0);

        // T4 / T5: continuous requests from reset on both instances.
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        we_a[0] = 4'h0; we_a[1] = 4'h0;
        adr_a[0] = 3'd3; adr_a[1] = 3'd5;
        adr_b[0] = 3'd2; adr_b[1] = 3'd6;
        req_a = 2'b11;
        req_b = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e.port = k[0];
            e.data = k[0] ? ref_a[5] : ref_a[3];
            sb_a.push_back(e);
            e.port = 1'b0;
            e.data = ref_b[2];
            sb_b.push_back(e);
        end
        last_a = 0; n_ack_a = 0; n_ack0_b = 0; n_ack1_b = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (ack0_a | ack1_a) begin
                check("rr_ack_cycle", 32'(i), 32'(last_a == 0 ? 2 : last_a + 3));
                last_a = i;
                n_ack_a++;
                pop_a();
            end
            if (ack0_b) begin
                n_ack0_b++;
                pop_b();
            end
            if (ack1_b) n_ack1_b++;
        end
        check("rr_ack_count", 32'(n_ack_a), 32'd4);
        check("fp_ack0_count", 32'(n_ack0_b), 32'd4);
        check("fp_ack1_never", 32'(n_ack1_b), 32'd0);

        req_a = 2'b00;
        req_b[0] = 1'b0;
        e.port = 1'b1;
        e.data = ref_b[6];
        sb_b.push_back(e);
        got = 0;
        for (int i = 0; i < 3 && got == 0; i++) begin
            @(negedge CLK);
            if (ack1_b) begin
                got = 1;
                pop_b();
            end
        end
        check("fp_port1_served", 32'(got), 32'd1);
        req_b[1] = 1'b0;

        repeat (4) @(negedge CLK);
        check("idle_en_a", 32'(ram_en_a), 32'd0);
        check("sb_a_drained", 32'(sb_a.size()), 32'd0);
        check("sb_b_drained", 32'(sb_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
